// File: rtl/issue_unit.sv
// ---------------------------------------------------------------------------
// issue_unit
//   Issue scheduler for the Int, LdSt, Mult and Div issue queues. Each cycle
//   it grants issue to ready queues so that no two results ever land on the
//   single CDB in the same cycle, and it tracks the busy time of the
//   non-pipelined divider. The registered CDB owner outputs steer the
//   CDB result mux.
//
//   Result latencies (issue -> CDB): Int = Lsb = 1, Mult = MUL_LAT,
//   Div = DIV_LAT.
//
// Ports
//   Clk             in   clock
//   Rst             in   asynchronous reset, active-high
//   IssInt_Ready    in   int queue has a ready entry
//   IssLsb_Ready    in   load/store queue has a ready entry
//   IssMul_Ready    in   mult queue has a ready entry
//   IssDiv_Ready    in   div queue has a ready entry
//   RB_Flush_Valid  in   flush; every grant is suppressed this cycle
//   Iss_Int         out  grant to int queue
//   Iss_Lsb         out  grant to load/store queue
//   Iss_Mult        out  grant to mult queue
//   Iss_Div         out  grant to div queue
//   Iss_Cdb_Valid   out  registered; some unit owns the CDB this cycle
//   Iss_Cdb_Sel     out  registered owner: 00 int, 01 lsb, 10 mult, 11 div
// ---------------------------------------------------------------------------
module issue_unit #(
    parameter int MUL_LAT = 4,   // 2 <= MUL_LAT < DIV_LAT
    parameter int DIV_LAT = 7    // DIV_LAT <= 15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       IssInt_Ready,
    input  logic       IssLsb_Ready,
    input  logic       IssMul_Ready,
    input  logic       IssDiv_Ready,
    input  logic       RB_Flush_Valid,
    output logic       Iss_Int,
    output logic       Iss_Lsb,
    output logic       Iss_Mult,
    output logic       Iss_Div,
    output logic       Iss_Cdb_Valid,
    output logic [1:0] Iss_Cdb_Sel
);

    localparam logic [1:0] OWN_INT = 2'b00;
    localparam logic [1:0] OWN_LSB = 2'b01;
    localparam logic [1:0] OWN_MUL = 2'b10;
    localparam logic [1:0] OWN_DIV = 2'b11;

    // Slot k of r_rsv/r_own means "CDB taken k cycles from now". The slot at
    // distance DIV_LAT is always empty at a clock edge (nothing reserves
    // further than the longest latency and it shifts down immediately), so
    // only slots 0..DIV_LAT-1 are stored and slot DIV_LAT reads as free.
    logic [DIV_LAT-1:0]       r_rsv;
    logic [DIV_LAT-1:0][1:0]  r_own;
    logic [3:0]               r_div_cnt;
    logic                     r_lru_lsb;   // 1: Lsb wins the next Int/Lsb tie

    logic                     w_elig_int;
    logic                     w_elig_lsb;
    logic                     w_gnt_int;
    logic                     w_gnt_lsb;
    logic                     w_gnt_mul;
    logic                     w_gnt_div;
    logic [DIV_LAT-1:0]       w_rsv_nxt;
    logic [DIV_LAT-1:0][1:0]  w_own_nxt;

    // Grants are combinational so the queue can issue in the same cycle.
    always_comb begin
        w_elig_int = IssInt_Ready & ~r_rsv[1] & ~RB_Flush_Valid;
        w_elig_lsb = IssLsb_Ready & ~r_rsv[1] & ~RB_Flush_Valid;
        // Int and Lsb share slot 1: on a tie the less recently granted wins.
        w_gnt_int  = w_elig_int & (~w_elig_lsb | ~r_lru_lsb);
        w_gnt_lsb  = w_elig_lsb & (~w_elig_int |  r_lru_lsb);
        w_gnt_mul  = IssMul_Ready & ~r_rsv[MUL_LAT] & ~RB_Flush_Valid;
        w_gnt_div  = IssDiv_Ready & (r_div_cnt == 4'd0) & ~RB_Flush_Valid;
    end

    // Shift the reservation window down one slot and drop new grants in at
    // their latency. Latencies are distinct, so the insert points never clash.
    always_comb begin
        w_rsv_nxt = {1'b0, r_rsv[DIV_LAT-1:1]};
        w_own_nxt = {2'b00, r_own[DIV_LAT-1:1]};
        if (w_gnt_int) begin
            w_rsv_nxt[0] = 1'b1;
            w_own_nxt[0] = OWN_INT;
        end
        if (w_gnt_lsb) begin
            w_rsv_nxt[0] = 1'b1;
            w_own_nxt[0] = OWN_LSB;
        end
        if (w_gnt_mul) begin
            w_rsv_nxt[MUL_LAT-1] = 1'b1;
            w_own_nxt[MUL_LAT-1] = OWN_MUL;
        end
        if (w_gnt_div) begin
            w_rsv_nxt[DIV_LAT-1] = 1'b1;
            w_own_nxt[DIV_LAT-1] = OWN_DIV;
        end
    end

    // Flush only blocks new grants; reservations already made keep moving
    // so in-flight results still reach the CDB.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rsv     <= '0;
            r_own     <= '0;
            r_div_cnt <= 4'd0;
            r_lru_lsb <= 1'b0;
        end else begin
            r_rsv <= w_rsv_nxt;
            r_own <= w_own_nxt;
            if (w_gnt_div)
                r_div_cnt <= 4'(DIV_LAT);
            else if (r_div_cnt != 4'd0)
                r_div_cnt <= r_div_cnt - 4'd1;
            if (w_gnt_int)
                r_lru_lsb <= 1'b1;
            else if (w_gnt_lsb)
                r_lru_lsb <= 1'b0;
        end
    end

    assign Iss_Int       = w_gnt_int;
    assign Iss_Lsb       = w_gnt_lsb;
    assign Iss_Mult      = w_gnt_mul;
    assign Iss_Div       = w_gnt_div;
    assign Iss_Cdb_Valid = r_rsv[0];
    assign Iss_Cdb_Sel   = r_own[0];

endmodule

// File: tb/tb_issue_unit.sv
module tb_issue_unit;

    localparam int M  = 4;
    localparam int D  = 7;
    localparam int NB = 8192;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       IssInt_Ready = 1'b0;
    logic       IssLsb_Ready = 1'b0;
    logic       IssMul_Ready = 1'b0;
    logic       IssDiv_Ready = 1'b0;
    logic       RB_Flush_Valid = 1'b0;
    logic       Iss_Int, Iss_Lsb, Iss_Mult, Iss_Div, Iss_Cdb_Valid;
    logic [1:0] Iss_Cdb_Sel;

    issue_unit #(.MUL_LAT(M), .DIV_LAT(D)) dut (
        .Clk(Clk), .Rst(Rst),
        .IssInt_Ready(IssInt_Ready), .IssLsb_Ready(IssLsb_Ready),
        .IssMul_Ready(IssMul_Ready), .IssDiv_Ready(IssDiv_Ready),
        .RB_Flush_Valid(RB_Flush_Valid),
        .Iss_Int(Iss_Int), .Iss_Lsb(Iss_Lsb), .Iss_Mult(Iss_Mult), .Iss_Div(Iss_Div),
        .Iss_Cdb_Valid(Iss_Cdb_Valid), .Iss_Cdb_Sel(Iss_Cdb_Sel)
    );

    always #5 Clk = ~Clk;

    wire [3:0] obs_g = {Iss_Int, Iss_Lsb, Iss_Mult, Iss_Div};

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a calendar of absolute cycles. booked[c] = 0 free,
    // 1 int, 2 lsb, 3 mult, 4 div owns the CDB in cycle c.
    int booked [NB];
    int last_div;
    int last_sl;          // 0: int granted most recently, 1: lsb
    logic g_i, g_l, g_m, g_d;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [3:0] exp_g;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) booked[i] = 0;
        last_div = -1000;
        last_sl  = 1;
    endtask

    task automatic cyc_begin(input logic ri, input logic rl, input logic rm,
                             input logic rd, input logic f);
        logic ei, el;
        @(negedge Clk);
        Rst = 1'b0;
        IssInt_Ready = ri; IssLsb_Ready = rl; IssMul_Ready = rm;
        IssDiv_Ready = rd; RB_Flush_Valid = f;
        #1;
        exp_valid = (booked[cyc] != 0);
        exp_sel   = exp_valid ? 2'(booked[cyc] - 1) : 2'b00;
        ei  = ri && (booked[cyc+1] == 0) && !f;
        el  = rl && (booked[cyc+1] == 0) && !f;
        g_m = rm && (booked[cyc+M] == 0) && !f;
        g_d = rd && (booked[cyc+D] == 0) && !f && (cyc - last_div > D);
        if (ei && el) begin
            g_i = (last_sl == 1);
            g_l = (last_sl == 0);
        end else begin
            g_i = ei;
            g_l = el;
        end
        exp_g = {g_i, g_l, g_m, g_d};
    endtask

    task automatic cyc_end();
        if (g_i) begin booked[cyc+1] = 1; last_sl = 0; end
        if (g_l) begin booked[cyc+1] = 2; last_sl = 1; end
        if (g_m) booked[cyc+M] = 3;
        if (g_d) begin booked[cyc+D] = 4; last_div = cyc; end
        @(posedge Clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        IssInt_Ready = 1'b0; IssLsb_Ready = 1'b0; IssMul_Ready = 1'b0;
        IssDiv_Ready = 1'b0; RB_Flush_Valid = 1'b0;
        model_reset();
        @(posedge Clk);
        cyc++;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        n_cmp++;
        if ({Iss_Cdb_Valid, Iss_Cdb_Sel} !== 3'b000) begin
            n_fail++; $display("FAIL reset_cdb: got %b want 000", {Iss_Cdb_Valid, Iss_Cdb_Sel});
        end
        n_cmp++;
        if (obs_g !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grants: got %b want 0000", obs_g);
        end
        @(posedge Clk);
        cyc++;
        cyc_begin(0, 0, 0, 0, 0);
        n_cmp++;
        if ({obs_g, Iss_Cdb_Valid, Iss_Cdb_Sel} !== 7'b0000000) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want 0000000", {obs_g, Iss_Cdb_Valid, Iss_Cdb_Sel});
        end
        cyc_end();
    endtask

    task automatic test_all_ready();
        logic [1:0] want_sel;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            cyc_begin(1, 1, 1, 1, 0);
            if (t == 0) begin
                n_cmp++;
                if (obs_g !== 4'b1011) begin
                    n_fail++; $display("FAIL all_ready_t0_grants: got %b want 1011", obs_g);
                end
            end
            if (t == 1) begin
                n_cmp++;
                if (obs_g !== 4'b0110) begin
                    n_fail++; $display("FAIL all_ready_t1_grants: got %b want 0110", obs_g);
                end
            end
            if (t == 1 || t == 2 || t == 4 || t == 7) begin
                want_sel = (t == 1) ? 2'b00 : (t == 2) ? 2'b01 : (t == 4) ? 2'b10 : 2'b11;
                n_cmp++;
                if ({Iss_Cdb_Valid, Iss_Cdb_Sel} !== {1'b1, want_sel}) begin
                    n_fail++; $display("FAIL all_ready_sel_t%0d: got %b want %b", t,
                                       {Iss_Cdb_Valid, Iss_Cdb_Sel}, {1'b1, want_sel});
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_int_lsb_alternate();
        logic [3:0] want;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            cyc_begin(t < 6, t < 6, 0, 0, 0);
            if (t < 6) begin
                want = (t % 2 == 0) ? 4'b1000 : 4'b0100;
                n_cmp++;
                if (obs_g !== want) begin
                    n_fail++; $display("FAIL alternate_t%0d: got %b want %b", t, obs_g, want);
                end
            end
            if (t >= 1) begin
                n_cmp++;
                if (Iss_Cdb_Valid !== 1'b1) begin
                    n_fail++; $display("FAIL alternate_valid_t%0d: got %b want 1", t, Iss_Cdb_Valid);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_div_busy();
        do_reset();
        for (int t = 0; t < 9; t++) begin
            cyc_begin(0, 0, 0, 1, 0);
            n_cmp++;
            if (Iss_Div !== (t == 0 || t == 8)) begin
                n_fail++; $display("FAIL div_busy_t%0d: got %b want %b", t, Iss_Div, (t == 0 || t == 8));
            end
            if (t == 7) begin
                n_cmp++;
                if ({Iss_Cdb_Valid, Iss_Cdb_Sel} !== 3'b111) begin
                    n_fail++; $display("FAIL div_result_t7: got %b want 111", {Iss_Cdb_Valid, Iss_Cdb_Sel});
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_slot_conflict();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            cyc_begin(t >= 3, 0, t == 0, 0, 0);
            if (t == 3 || t == 4) begin
                n_cmp++;
                if (Iss_Int !== (t == 4)) begin
                    n_fail++; $display("FAIL mul_blocks_int_t%0d: got %b want %b", t, Iss_Int, (t == 4));
                end
            end
            cyc_end();
        end
        do_reset();
        for (int t = 0; t < 4; t++) begin
            cyc_begin(0, 0, t == 3, t == 0, 0);
            if (t == 3) begin
                n_cmp++;
                if (Iss_Mult !== 1'b0) begin
                    n_fail++; $display("FAIL div_blocks_mul_t3: got %b want 0", Iss_Mult);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int t = 0; t < 8; t++) begin
            cyc_begin(t == 1, t == 1, t == 1, t <= 1, t == 1);
            if (t == 1) begin
                n_cmp++;
                if (obs_g !== 4'b0000) begin
                    n_fail++; $display("FAIL flush_grants_t1: got %b want 0000", obs_g);
                end
            end
            if (t == 7) begin
                n_cmp++;
                if ({Iss_Cdb_Valid, Iss_Cdb_Sel} !== 3'b111) begin
                    n_fail++; $display("FAIL flush_keeps_div_t7: got %b want 111", {Iss_Cdb_Valid, Iss_Cdb_Sel});
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int t = 0; t < 8; t++) begin
            if (t == 3) begin
                do_reset();
            end else begin
                cyc_begin(0, 0, 0, (t == 0 || t >= 4), 0);
                if (t == 4) begin
                    n_cmp++;
                    if (Iss_Div !== 1'b1) begin
                        n_fail++; $display("FAIL div_after_reset_t4: got %b want 1", Iss_Div);
                    end
                end
                if (t == 7) begin
                    n_cmp++;
                    if (Iss_Cdb_Valid !== 1'b0) begin
                        n_fail++; $display("FAIL reset_drops_div_t7: got %b want 0", Iss_Cdb_Valid);
                    end
                end
                cyc_end();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 255) == 0) begin
                do_reset();
            end else begin
                cyc_begin($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0);
                n_cmp++;
                if (obs_g !== exp_g) begin
                    n_fail++; $display("FAIL random_grants cyc %0d: got %b want %b", cyc, obs_g, exp_g);
                end
                n_cmp++;
                if ({Iss_Cdb_Valid, Iss_Cdb_Sel} !== {exp_valid, exp_sel}) begin
                    n_fail++; $display("FAIL random_cdb cyc %0d: got %b want %b", cyc,
                                       {Iss_Cdb_Valid, Iss_Cdb_Sel}, {exp_valid, exp_sel});
                end
                cyc_end();
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ready();
        test_int_lsb_alternate();
        test_div_busy();
        test_slot_conflict();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
